// File: rtl/alu_share_arb_pkg.sv
// alu_arb_pkg: opcode encodings and opcode legality helper shared by the
// ALU sharing arbiter and its users.
package alu_arb_pkg;

   localparam logic [3:0] OP_ADD   = 4'd0;
   localparam logic [3:0] OP_SUB   = 4'd1;
   localparam logic [3:0] OP_AND   = 4'd3;
   localparam logic [3:0] OP_OR    = 4'd4;
   localparam logic [3:0] OP_XOR   = 4'd5;
   localparam logic [3:0] OP_SHL   = 4'd6;
   localparam logic [3:0] OP_SHR   = 4'd7;
   localparam logic [3:0] OP_PASS0 = 4'd8;
   localparam logic [3:0] OP_PASS1 = 4'd9;
   localparam logic [3:0] OP_IDLE  = 4'd15;

   // Opcode 2 and 10..15 have no ALU function behind them.
   function automatic logic op_legal(input logic [3:0] op);
      case (op)
         4'd2, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15: op_legal = 1'b0;
         default:                                        op_legal = 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/alu_share_arb_if.sv
// alu_share_arb_if: requester-side bus of the ALU sharing arbiter
// (requests, operands, grant and tagged response).
interface alu_share_arb_if #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned SIZE = 32,
   parameter int unsigned IDW  = $clog2(NREQ)
);
   logic [NREQ-1:0]      req;
   logic [NREQ-1:0]      lock;
   logic [NREQ*4-1:0]    op;
   logic [NREQ*SIZE-1:0] a;
   logic [NREQ*SIZE-1:0] b;
   logic [NREQ-1:0]      gnt;
   logic                 rsp_valid;
   logic [IDW-1:0]       rsp_id;
   logic [SIZE-1:0]      rsp_data;
   logic                 rsp_err;

   modport master (
      output req, lock, op, a, b,
      input  gnt, rsp_valid, rsp_id, rsp_data, rsp_err
   );

   modport slave (
      input  req, lock, op, a, b,
      output gnt, rsp_valid, rsp_id, rsp_data, rsp_err
   );
endinterface

// File: rtl/alu_share_arb_rr_pick.sv
// rr_pick: combinational round-robin priority picker. Returns the first
// requester at or above ptr (wrapping) as one-hot and as an index.
module rr_pick #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] gnt_oh,
   output logic [IDW-1:0]  idx,
   output logic            found
);

   // Scan from ptr upward, wrapping, and stop at the first request.
   always_comb begin
      logic [IDW-1:0] j;
      gnt_oh = '0;
      idx    = '0;
      found  = 1'b0;
      j      = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         j = IDW'((32'(ptr) + k) % NREQ);
         if (!found && req[j]) begin
            found     = 1'b1;
            idx       = j;
            gnt_oh[j] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin arbiter sharing one registered ALU among NREQ
// requesters, with optional bounded lock bursts. Responses come back one
// cycle after the grant, tagged with the winner's ID.
// Optional feature: define ALU_ARB_OPCHK_EN to flag illegal opcodes on
// rsp_err; otherwise rsp_err is tied low.
module alu_share_arb
   import alu_arb_pkg::*;
#(
   parameter int unsigned NREQ      = 4,
   parameter int unsigned SIZE      = 32,
   parameter int unsigned MAX_BURST = 8,
   parameter int unsigned IDW       = $clog2(NREQ)
) (
   input  logic            clk,
   input  logic            rst_n,
   alu_share_arb_if.slave  bus,
   output logic [3:0]      alu_cfg,
   output logic [SIZE-1:0] alu_in0,
   output logic [SIZE-1:0] alu_in1,
   input  logic [SIZE-1:0] alu_out0
);

   localparam logic [7:0]     MAX_B   = 8'(MAX_BURST);
   localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

   logic [IDW-1:0]  ptr;
   logic [IDW-1:0]  last_w;
   logic [7:0]      burst_cnt;
   logic            chain;
   logic [NREQ-1:0] req_m;
   logic [NREQ-1:0] rr_oh;
   logic [IDW-1:0]  rr_idx;
   logic            rr_found;
   logic            hold;
   logic            any;
   logic [NREQ-1:0] gnt;
   logic [IDW-1:0]  w;
   logic            v_q;
   logic [IDW-1:0]  id_q;

   // Requests are ignored while reset is asserted so gnt reads 0.
   assign req_m = bus.req & {NREQ{rst_n}};

   rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
      .req    (req_m),
      .ptr    (ptr),
      .gnt_oh (rr_oh),
      .idx    (rr_idx),
      .found  (rr_found)
   );

   // Winner: locked re-grant of last cycle's winner, else round-robin pick.
   always_comb begin
      hold = chain && req_m[last_w] && bus.lock[last_w] && (burst_cnt < MAX_B);
      gnt  = rr_oh;
      w    = rr_idx;
      if (hold) begin
         gnt         = '0;
         gnt[last_w] = 1'b1;
         w           = last_w;
      end
      any = hold || rr_found;
   end

   // Steer the granted requester's opcode and operands onto the ALU.
   always_comb begin
      alu_cfg = OP_IDLE;
      alu_in0 = '0;
      alu_in1 = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            alu_cfg = bus.op[4*i +: 4];
            alu_in0 = bus.a[SIZE*i +: SIZE];
            alu_in1 = bus.b[SIZE*i +: SIZE];
         end
      end
   end

   // Pointer and burst tracking; ptr holds across locked re-grants.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr       <= '0;
         last_w    <= '0;
         burst_cnt <= '0;
         chain     <= 1'b0;
      end else if (any) begin
         chain  <= 1'b1;
         last_w <= w;
         if (hold) begin
            burst_cnt <= burst_cnt + 8'd1;
         end else begin
            burst_cnt <= 8'd1;
            ptr       <= (w == LAST_ID) ? '0 : w + 1'b1;
         end
      end else begin
         chain <= 1'b0;
      end
   end

   // Response tag pipeline, aligned with the ALU's registered result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q  <= 1'b0;
         id_q <= '0;
      end else begin
         v_q  <= any;
         id_q <= w;
      end
   end

   assign bus.gnt       = gnt;
   assign bus.rsp_valid = v_q;
   assign bus.rsp_id    = id_q;
   assign bus.rsp_data  = alu_out0;

`ifdef ALU_ARB_OPCHK_EN
   logic err_q;

   // Illegal-opcode flag travels with the response valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= any && !op_legal(alu_cfg);
      end
   end

   assign bus.rsp_err = err_q;
`else
   assign bus.rsp_err = 1'b0;
`endif

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Round-robin arbiter that shares one registered ALU function cell (opcodes: add, sub, and, or, xor, shl, shr, pass-in0, pass-in1) among NREQ requesters inside a CGRA tile. Each cycle it grants at most one requester and drives the ALU's in0, in1 and config_sig. One cycle later it returns the ALU result tagged with the winner's ID. An optional lock lets one requester hold the ALU for a bounded burst.

## Interface
- NREQ, 4: number of requesters (2..8)
- SIZE, 32: datapath width, equal to the ALU size parameter
- MAX_BURST, 8: maximum consecutive grants under lock (1..255)
- IDW, $clog2(NREQ): response ID width
- clk  in  1  clock; all state on posedge
- rst_n  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester request
- lock  in  NREQ  per-requester burst-hold request; qualified by req
- op  in  NREQ*4  per-requester opcode; slice i = [4i+3:4i]
- a  in  NREQ*SIZE  per-requester operand 0
- b  in  NREQ*SIZE  per-requester operand 1
- gnt  out  NREQ  one-hot grant, combinational
- alu_cfg  out  4  drives ALU config_sig
- alu_in0  out  SIZE  drives ALU in0
- alu_in1  out  SIZE  drives ALU in1
- alu_out0  in  SIZE  ALU registered result
- rsp_valid  out  1  result valid
- rsp_id  out  IDW  requester that owns rsp_data
- rsp_data  out  SIZE  equals alu_out0
- rsp_err  out  1  illegal opcode flag (ALU_ARB_OPCHK_EN only, else tied 0)

## Operation
- Round-robin pointer ptr (IDW bits), reset 0. The winner is the first i with req[i]=1, searching from ptr upward and wrapping. After a grant to w, ptr becomes (w+1) mod NREQ.
- Lock:
  - If the previous cycle granted w, req[w]&lock[w] is still 1 and burst_cnt < MAX_BURST, then w wins again and ptr holds.
  - burst_cnt resets to 1 on each fresh grant and increments on each locked re-grant.
  - At MAX_BURST, the next winner is chosen by normal round-robin from w+1. w may win again only if no other requester is asserting req.
- Idle (no req): gnt=0, alu_cfg=4'hF (ALU outputs 0), alu_in0/alu_in1=0, ptr and burst state unchanged except the lock chain breaks.
- Granted: alu_cfg=op[w], alu_in0=a[w], alu_in1=b[w].
- A request is consumed in the cycle gnt[i]=1. A requester keeping req high issues a new operation each granted cycle.
- Response pipeline:
  - v_q and id_q are registered from (|gnt, w).
  - rsp_valid=v_q, rsp_id=id_q, rsp_data=alu_out0 (pass-through).
- Reset:
  - All outputs and state clear: gnt=0, rsp_valid=0, rsp_id=0, rsp_err=0, ptr=0, burst_cnt=0, lock chain broken.
  - An operation in flight when rst_n asserts is discarded, with no response.
  - The first cycle after rst_n deasserts has rsp_valid=0.

## Timing
- gnt and the ALU drive are combinational from req, lock and the registered state, within the same cycle t.
- The ALU captures at the posedge ending t. The response appears in cycle t+1: latency exactly 1, throughput 1 operation per cycle.
- Back-to-back grants to different requesters produce back-to-back responses with distinct rsp_id.
- No backpressure. Consumers must accept rsp_valid unconditionally.

## Configuration
- ALU_ARB_OPCHK_EN defined:
  - Opcodes 2 and 10..15 are illegal.
  - An illegal opcode is still granted and forwarded, and the ALU returns 0.
  - err_q is registered alongside v_q, so rsp_err=1 with rsp_valid.
- ALU_ARB_OPCHK_EN undefined: no check logic; rsp_err tied 0.

## Structure
- Package alu_arb_pkg holds:
  - opcode localparams: OP_ADD=0, OP_SUB=1, OP_AND=3, OP_OR=4, OP_XOR=5, OP_SHL=6, OP_SHR=7, OP_PASS0=8, OP_PASS1=9, OP_IDLE=15
  - function op_legal(logic [3:0])
- One sub-module, rr_pick, is natural: a combinational round-robin priority picker with inputs req and ptr, and outputs one-hot and index.

## Test plan
- Single requester, reset then req[1]=1 with op=0, a=5, b=7: gnt=0010 in cycle t; in t+1 rsp_valid=1, rsp_id=1, rsp_data=12.
- All four requesters request continuously, op=8, a=i: grants rotate 0,1,2,3,0 and responses return data 0,1,2,3,0 one cycle behind.
- Lock with MAX_BURST=3: req=1111 and lock[2]=1 from a grant to 2: grants 2,2,2,3,0.
- Idle cycle after a burst: alu_cfg=F, gnt=0, next rsp_valid=0, ptr unchanged.
- Reset mid-operation: rst_n low in the cycle after a grant gives rsp_valid=0 immediately; after release, the first grant goes to the lowest requesting index.
- ALU_ARB_OPCHK_EN: op=2 gives rsp_valid=1, rsp_err=1, rsp_data=0; op=5 gives rsp_err=0.
